axilmaster: RTL

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command port into AXI-Lite read and write transactions and returns one response per command. It drives register slaves such as the GPIO peripheral from firmware-less control logic, debug bridges, or self-checking benches. It also counts cycles per transaction and flags slaves that stall beyond a programmable watchdog limit.

---
 rtl/axilmaster.sv | 118 +++++++++++
 1 files changed

// File: rtl/axilmaster.sv
// axilmaster: single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
module axilmaster #(
  parameter int ADDR_W = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESET,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [31:0]       i_cmd_wdata,
  input  logic [3:0]        i_cmd_wstrb,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_data,
  output logic [1:0]        o_rsp_resp,
  output logic              o_rsp_we,
  output logic              o_timeout,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  input  logic [1:0]        M_AXI_BRESP,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [2:0]        M_AXI_ARPROT,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP
);
  localparam logic [2:0] IDLE = 3'd0, WADDR = 3'd1, WRESP = 3'd2, RADDR = 3'd3, RDATA = 3'd4, RSP = 3'd5;
  localparam logic [15:0] LIM = 16'(TIMEOUT);
  logic [2:0] state, nxt;
  logic [ADDR_W-1:0] addr;
  logic [15:0] cnt;
  logic acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, busy;
  assign acc   = o_cmd_ready && i_cmd_valid;
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY && M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY && M_AXI_RVALID;
  assign busy  = state inside {WADDR, WRESP, RADDR, RDATA};
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = state == RADDR;
  assign M_AXI_BREADY  = state == WRESP;
  assign M_AXI_RREADY  = state == RDATA;
  assign o_rsp_valid   = state == RSP;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc ? (i_cmd_we ? WADDR : RADDR) : IDLE;
      WADDR:   nxt = ((M_AXI_AWVALID && !M_AXI_AWREADY) || (M_AXI_WVALID && !M_AXI_WREADY)) ? WADDR : WRESP;
      WRESP:   nxt = b_hs ? RSP : WRESP;
      RADDR:   nxt = ar_hs ? RDATA : RADDR;
      RDATA:   nxt = r_hs ? RSP : RDATA;
      RSP:     nxt = i_rsp_ready ? IDLE : RSP;
      default: nxt = IDLE;
    endcase
  end
  // o_cmd_ready is registered from the next state so no input reaches it combinationally
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      o_cmd_ready   <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      addr          <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      o_rsp_we      <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_resp    <= '0;
      cnt           <= '0;
      o_timeout     <= 1'b0;
    end else begin
      state       <= nxt;
      o_cmd_ready <= nxt == IDLE;
      if (acc) begin
        addr          <= i_cmd_addr & ~ADDR_W'(3);
        M_AXI_WDATA   <= i_cmd_wdata;
        M_AXI_WSTRB   <= i_cmd_wstrb;
        o_rsp_we      <= i_cmd_we;
        M_AXI_AWVALID <= i_cmd_we;
        M_AXI_WVALID  <= i_cmd_we;
        cnt           <= '0;
        o_timeout     <= 1'b0;
      end else begin
        if (aw_hs) M_AXI_AWVALID <= 1'b0;
        if (w_hs) M_AXI_WVALID <= 1'b0;
        if (busy && cnt != LIM) begin
          cnt <= cnt + 16'd1;
          if (cnt + 16'd1 == LIM) o_timeout <= 1'b1;
        end
      end
      if (b_hs) begin
        o_rsp_resp <= M_AXI_BRESP;
        o_rsp_data <= '0;
      end
      if (r_hs) begin
        o_rsp_resp <= M_AXI_RRESP;
        o_rsp_data <= M_AXI_RDATA;
      end
    end
  end
endmodule
